instr_prefetch_queue: RTL and testbench

//  Front end of the pipeline, directly upstream of Buffer_IFID. Owns the fetch PC and

---
 rtl/instr_prefetch_queue.sv | 109 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Owns the fetch PC and prefetches instruction words in order into a show-ahead FIFO feeding IF/ID.
// A response in cycle R is visible on IFID in R+1; requests are issued only while FIFO + in-flight < DEPTH.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_pc,
    output logic                   o_imem_req_valid,
    output logic [31:0]            o_imem_req_addr,
    input  logic                   i_imem_req_ready,
    input  logic                   i_imem_resp_valid,
    input  logic [31:0]            i_imem_resp_data,
    input  logic                   i_ifid_ready,
    output logic                   o_ifid_valid,
    output logic [31:0]            o_ifid_instruction,
    output logic [31:0]            o_ifid_pc_next,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_tag;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc_next [DEPTH];

    logic [CW:0]   w_used;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;

    assign w_used     = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req_fire = o_imem_req_valid && i_imem_req_ready;
    assign w_push     = i_imem_resp_valid && (r_drop == '0) && !i_redirect;
    assign w_pop      = o_ifid_valid && i_ifid_ready;

    // Reset gates the request combinationally so it drops the moment reset asserts.
    assign o_imem_req_valid   = i_rst_n && !i_redirect && (w_used < DEPTH_L);
    assign o_imem_req_addr    = r_fetch_pc;
    assign o_ifid_valid       = (r_count != '0) && !i_redirect;
    assign o_ifid_instruction = r_instr[r_rd_ptr];
    assign o_ifid_pc_next     = r_pc_next[r_rd_ptr];
    assign o_count            = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_tag      <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (i_redirect) begin
            // Every request still outstanding after this cycle belongs to the old stream.
            r_fetch_pc <= i_redirect_pc;
            r_tag      <= i_redirect_pc;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= r_inflight - CW'(i_imem_resp_valid);
            r_drop     <= r_inflight - CW'(i_imem_resp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(i_imem_resp_valid);
            if (i_imem_resp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_tag    <= r_tag + 32'd4;
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i]   <= '0;
                r_pc_next[i] <= '0;
            end
        end else if (w_push) begin
            r_instr[r_wr_ptr]   <= i_imem_resp_data;
            r_pc_next[r_wr_ptr] <= r_tag + 32'd4;
        end
    end

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: queue-based reference model plus an in-order variable-latency memory.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        ifid_ready = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcn;
    logic [2:0]  count;

    logic        h_zero = 1'b0;
    logic [31:0] h_zero_pc = '0;
    logic        h_one = 1'b1;
    logic        h_req_valid;
    logic [31:0] h_req_addr;
    logic        h_resp_valid = 1'b0;
    logic [31:0] h_resp_data = '0;
    logic        h_ifid_valid;
    logic [31:0] h_instr;
    logic [31:0] h_pcn;
    logic [2:0]  h_count;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_imem_req_valid(req_valid), .o_imem_req_addr(req_addr), .i_imem_req_ready(req_ready),
        .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data), .i_ifid_ready(ifid_ready),
        .o_ifid_valid(ifid_valid), .o_ifid_instruction(ifid_instr), .o_ifid_pc_next(ifid_pcn),
        .o_count(count)
    );

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_redirect(h_zero), .i_redirect_pc(h_zero_pc),
        .o_imem_req_valid(h_req_valid), .o_imem_req_addr(h_req_addr), .i_imem_req_ready(h_one),
        .i_imem_resp_valid(h_resp_valid), .i_imem_resp_data(h_resp_data), .i_ifid_ready(h_one),
        .o_ifid_valid(h_ifid_valid), .o_ifid_instruction(h_instr), .o_ifid_pc_next(h_pcn),
        .o_count(h_count)
    );

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] instr; logic [31:0] pcn; } ent_t;

    req_t        out_q[$];
    mem_t        mem_q[$];
    ent_t        fifo_q[$];
    logic [31:0] m_pc;
    int          cyc;
    int          lat = 1;
    int          resp_pct = 100;
    int          total = 0;
    int          bad = 0;
    int          h_n;
    bit          h_seen;
    bit          h_pend;
    logic [31:0] h_pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        resp_valid = 1'b0;
        h_resp_valid = 1'b0;
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_instr", ifid_instr, 32'd0);
        check("rst_pcn", ifid_pcn, 32'd0);
        check("rst_hi_req_valid", 32'(h_req_valid), 32'd0);
        check("rst_hi_count", 32'(h_count), 32'd0);
        out_q.delete();
        mem_q.delete();
        fifo_q.delete();
        m_pc = 32'h0;
        h_n = 0;
        h_seen = 1'b0;
        h_pend = 1'b0;
        h_pend_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock: drive memory responses, compare outputs to the model, advance the model.
    task automatic cycle();
        bit   rsp, fire, pop, exp_rv, exp_iv;
        req_t r;
        mem_t m;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < resp_pct);
        resp_valid = rsp;
        resp_data = rsp ? mem_word(mem_q[0].addr) : $urandom;
        h_resp_valid = h_pend;
        h_resp_data = mem_word(h_pend_addr);
        #1;
        exp_rv = !redirect && (fifo_q.size() + out_q.size() < 4);
        exp_iv = (fifo_q.size() > 0) && !redirect;
        check("req_valid", 32'(req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", req_addr, m_pc);
        check("ifid_valid", 32'(ifid_valid), 32'(exp_iv));
        check("count", 32'(count), 32'(fifo_q.size()));
        if (exp_iv) begin
            check("ifid_instr", ifid_instr, fifo_q[0].instr);
            check("ifid_pcn", ifid_pcn, fifo_q[0].pcn);
        end
        fire = exp_rv && req_ready;
        pop = exp_iv && ifid_ready;
        if (pop) void'(fifo_q.pop_front());
        if (rsp) begin
            m = mem_q.pop_front();
            r = out_q.pop_front();
            if (!r.stale && !redirect)
                fifo_q.push_back('{instr: mem_word(m.addr), pcn: r.addr + 32'd4});
        end
        if (fire) begin
            out_q.push_back('{addr: m_pc, stale: 1'b0});
            mem_q.push_back('{addr: m_pc, due: cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (redirect) begin
            fifo_q.delete();
            foreach (out_q[i]) out_q[i].stale = 1'b1;
            m_pc = redirect_pc;
        end
        if (h_req_valid && h_n < 3) begin
            check("hi_addr", h_req_addr, 32'hFFFF_FFF8 + 32'(h_n) * 32'd4);
            h_n++;
        end
        if (h_ifid_valid && !h_seen) begin
            check("hi_pcn", h_pcn, 32'hFFFF_FFFC);
            check("hi_instr", h_instr, mem_word(32'hFFFF_FFF8));
            h_seen = 1'b1;
        end
        h_pend = h_req_valid;
        h_pend_addr = h_req_addr;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] tmp;
        int i;

        // Free-running fetch, 1-cycle memory, consumer always ready.
        do_reset();
        req_ready = 1'b1; ifid_ready = 1'b1; lat = 1; resp_pct = 100;
        repeat (12) cycle();

        // Consumer stalled from reset: exactly DEPTH requests, then drain.
        do_reset();
        req_ready = 1'b1; ifid_ready = 1'b0; lat = 1;
        repeat (10) cycle();
        #1;
        check("stall_count", 32'(count), 32'd4);
        check("stall_req_valid", 32'(req_valid), 32'd0);
        ifid_ready = 1'b1;
        repeat (15) cycle();

        // Redirect with three slow requests in flight.
        req_ready = 1'b0;
        for (i = 0; i < 60 && (out_q.size() > 0 || fifo_q.size() > 0); i++) cycle();
        check("t3_drained", 32'(out_q.size() + fifo_q.size()), 32'd0);
        lat = 5; req_ready = 1'b1;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        #1;
        check("t3_next_addr", req_addr, 32'h100);
        for (i = 0; i < 30 && !ifid_valid; i++) cycle();
        check("t3_valid_seen", 32'(ifid_valid), 32'd1);
        check("t3_first_pcn", ifid_pcn, 32'h104);
        repeat (10) cycle();

        // Redirect coinciding with a response and a would-be pop.
        lat = 2;
        for (i = 0; i < 40 && !(fifo_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc); i++) cycle();
        check("t4_setup", 32'(fifo_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h2000;
        cycle();
        redirect = 1'b0;
        #1;
        check("t4_count", 32'(count), 32'd0);
        repeat (10) cycle();

        // Back-to-back redirects, the second one into the top of the address space.
        redirect = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        repeat (15) cycle();

        // Randomised traffic.
        resp_pct = 70;
        for (int k = 0; k < 1500; k++) begin
            req_ready = ($urandom_range(3) != 0);
            ifid_ready = ($urandom_range(2) != 0);
            lat = $urandom_range(6, 1);
            redirect = ($urandom_range(19) == 0);
            tmp = $urandom;
            redirect_pc = {tmp[31:2], 2'b00};
            cycle();
        end
        redirect = 1'b0;

        // Reset asserted mid-stream with three entries queued.
        resp_pct = 100; lat = 1; req_ready = 1'b1; ifid_ready = 1'b0;
        for (i = 0; i < 60 && fifo_q.size() != 3; i++) cycle();
        #1;
        check("t6_pre_count", 32'(count), 32'd3);
        do_reset();
        ifid_ready = 1'b1;
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
